lrf_axis_out_stage: RTL and testbench
=====================================

Name: lrf_axis_out_stage

Overview:
- AXI4-Stream egress and flow-control stage directly downstream of the LRF fusion datapath.
- Owns the datapath's advance enable (pipe_en), tags each accepted input beat with valid/last, and aligns the tags to the fixed-latency pipeline output.
- Buffers pipeline results in a credit-managed FIFO, so m_axis_tready backpressure never drops a beat and never reaches s_axis_tready combinationally.
- Regenerates tlast from a beat counter and flags input framing errors.

Parameters:
- PIXELS_PER_BEAT, 16: pixels per beat, 8 bits each.
- IMAGE_DIM, 512: image side length in pixels.
- PIPELINE_DELAY, 3: number of pipe_en pulses from input to a valid pipe_data; must be ≥1.
- FIFO_DEPTH, 8: output FIFO entries; must be ≥ PIPELINE_DELAY+2 for full throughput (elaboration check).
- DATA_WIDTH, 8*PIXELS_PER_BEAT: beat width in bits.

Ports:
- s_axis_aclk  in  1  single clock.
- s_axis_aresetn  in  1  reset, asynchronous, active-low.
- s_axis_tvalid  in  1  upstream beat valid.
- s_axis_tlast  in  1  upstream end-of-frame marker.
- s_axis_tready  out  1  upstream ready; registered-path only.
- pipe_en  out  1  advance enable to datapath (replaces step).
- pipe_data  in  DATA_WIDTH  datapath output for the tag at stage PIPELINE_DELAY-1.
- m_axis_tdata  out  DATA_WIDTH  output beat.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  end of frame (counter-generated).
- frame_err  out  1  sticky: input tlast disagreed with beat count.

Behaviour:
- Reset (async assert, sync release): tag pipe cleared, FIFO empty, beat counter 0.
  - Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0, pipe_en=0, frame_err=0.
  - Reset mid-stream discards all in-flight and buffered beats; no partial output is ever emitted after release.
- Credit: used = fifo_count + inflight, where inflight = number of valid tags in stages 0..PIPELINE_DELAY-1. Both come from registers.
- s_axis_tready = (used < FIFO_DEPTH), registered-derived, with no path from m_axis_tready.
- accept = s_axis_tvalid & s_axis_tready.
- drain = ~accept & (inflight != 0).
- pipe_en = accept | drain. A drain inserts a bubble (tag valid=0), which consumes no credit.
- Tag pipe, shifted on pipe_en only:
  - tag[0] <= {accept, gen_last}; tag[k] <= tag[k-1].
  - When pipe_en=0 all tags hold.
- FIFO write = pipe_en & tag[PIPELINE_DELAY-1].valid; it writes {pipe_data, tag.last}.
  - Credit guarantees space. A write to a full FIFO is a design error, covered by an assertion.
- FIFO read = m_axis_tvalid & m_axis_tready. Simultaneous read and write on a full or empty FIFO is legal; count is unchanged when both occur.
- m_axis_tvalid = FIFO non-empty. tdata/tlast are the FIFO head and stay stable while tvalid=1 & tready=0.
- Latency: a beat accepted at cycle 0 with pipe_en continuous appears on m_axis at cycle PIPELINE_DELAY+1.
  - Throughput is 1 beat/cycle with m_axis_tready=1.
  - With no further input, the drain flushes the last beats without stalling.
- Beat counter:
  - Width clog2(BEATS_PER_IMAGE), where BEATS_PER_IMAGE = IMAGE_DIM²/PIXELS_PER_BEAT.
  - Increments on accept and wraps to 0 after BEATS_PER_IMAGE-1.
  - gen_last = (counter == BEATS_PER_IMAGE-1).
- Error flag: on accept, if s_axis_tlast != gen_last, frame_err <= 1 (sticky until reset). Output framing always follows gen_last; input tlast is check-only.

Decomposition:
- Package lrf_pkg: PIXEL_W=8, BEATS_PER_IMAGE, N_BEATS_PER_IMAGE, tag bundle layout (valid, last).
  - The LRF top and this stage share the package.
- Sub-module lrf_sync_fifo: parameters WIDTH, DEPTH.
  - Registered count; full/empty flags; simultaneous read and write supported.
  - Instantiated once with WIDTH = DATA_WIDTH+1.

Test Plan:
- Streaming: IMAGE_DIM=64, PPB=16 (256 beats), with s_axis_tvalid and m_axis_tready held high.
  - First m_axis_tvalid at cycle 4; 256 beats in order; tdata matches an ideal delay model.
  - m_axis_tlast only on beat 255; frame_err=0.
- Backpressure: m_axis_tready=0 for 20 cycles mid-frame.
  - s_axis_tready falls once used reaches 8.
  - No beat is lost or duplicated; head tdata stays stable while stalled.
  - Stream resumes at full rate after release.
- Drain: send 5 beats, then hold s_axis_tvalid=0.
  - pipe_en continues for 3 bubble cycles; all 5 beats emerge.
  - pipe_en then goes to 0 with inflight=0.
- Framing error: assert s_axis_tlast on beat 100.
  - frame_err=1 from the next cycle onward; m_axis_tlast is still only on beat 255.
- Wrap: two back-to-back frames.
  - Counter wraps 255→0; tlast appears exactly at output beats 255 and 511.
- Reset: assert s_axis_aresetn=0 mid-frame with a full FIFO.
  - All outputs are 0 immediately (asynchronous).
  - After release, the first output beat equals the first newly accepted beat; the counter restarts at 0.

Source files
------------

// File: rtl/lrf_pkg.sv
// Shared definitions for the LRF fusion datapath and its AXI4-Stream egress stage.
package lrf_pkg;

    localparam int PIXEL_W             = 8;
    localparam int DEF_IMAGE_DIM       = 512;
    localparam int DEF_PIXELS_PER_BEAT = 16;
    localparam int BEATS_PER_IMAGE     = (DEF_IMAGE_DIM * DEF_IMAGE_DIM) / DEF_PIXELS_PER_BEAT;
    // Beat-counter width at the default image geometry.
    localparam int N_BEATS_PER_IMAGE   = $clog2(BEATS_PER_IMAGE);

    typedef struct packed {
        logic valid;
        logic last;
    } lrf_tag_t;

    function automatic int beats_per_image(input int dim, input int ppb);
        return (dim * dim) / ppb;
    endfunction

endpackage

// File: rtl/lrf_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; read and write may occur together
// in the same cycle, including when full or empty.
module lrf_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_rd   = rd_en & ~empty;
    // A read in the same cycle frees the slot a write to a full FIFO needs.
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= next_ptr(wr_ptr);
            if (do_rd) rd_ptr <= next_ptr(rd_ptr);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && full && !rd_en));

endmodule

// File: rtl/lrf_axis_out_stage.sv
// AXI4-Stream egress stage: owns the datapath advance enable, tags beats through the
// fixed-latency pipe, and buffers results in a credit-managed output FIFO.
module lrf_axis_out_stage
    import lrf_pkg::*;
#(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int PIPELINE_DELAY  = 3,
    parameter int FIFO_DEPTH      = 8,
    parameter int DATA_WIDTH      = PIXEL_W * PIXELS_PER_BEAT
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_aresetn,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  pipe_en,
    input  logic [DATA_WIDTH-1:0] pipe_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  frame_err
);

    localparam int BPI    = beats_per_image(IMAGE_DIM, PIXELS_PER_BEAT);
    localparam int BC_W   = (BPI > 1) ? $clog2(BPI) : 1;
    localparam int IF_W   = $clog2(PIPELINE_DELAY + 1);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int USED_W = $clog2(FIFO_DEPTH + PIPELINE_DELAY + 1);

    if (PIPELINE_DELAY < 1) begin : g_bad_delay
        $error("lrf_axis_out_stage: PIPELINE_DELAY must be at least 1");
    end
    if (FIFO_DEPTH < PIPELINE_DELAY + 2) begin : g_bad_depth
        $error("lrf_axis_out_stage: FIFO_DEPTH must be at least PIPELINE_DELAY+2");
    end

    lrf_tag_t            tag [PIPELINE_DELAY];
    logic [BC_W-1:0]     beat_cnt;
    logic                gen_last;
    logic                accept;
    logic                drain;
    logic                rdy_q;
    logic [IF_W-1:0]     inflight;
    logic [CNT_W-1:0]    fifo_count;
    logic [USED_W-1:0]   used;
    logic                fifo_wr;
    logic                fifo_rd;
    logic                fifo_full;
    logic                fifo_empty;
    logic [DATA_WIDTH:0] fifo_head;

    always_comb begin
        inflight = '0;
        for (int k = 0; k < PIPELINE_DELAY; k++) begin
            inflight = inflight + IF_W'(tag[k].valid);
        end
    end

    // Credit is computed from registered state only, so downstream ready never
    // reaches s_axis_tready combinationally.
    assign used          = USED_W'(fifo_count) + USED_W'(inflight);
    assign s_axis_tready = rdy_q & (used < USED_W'(FIFO_DEPTH));
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign drain         = ~accept & (inflight != '0);
    assign pipe_en       = accept | drain;
    assign gen_last      = (beat_cnt == BC_W'(BPI - 1));

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            rdy_q     <= 1'b0;
            beat_cnt  <= '0;
            frame_err <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (accept) begin
                beat_cnt <= gen_last ? '0 : beat_cnt + BC_W'(1);
                if (s_axis_tlast != gen_last) frame_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            for (int k = 0; k < PIPELINE_DELAY; k++) tag[k] <= '0;
        end else if (pipe_en) begin
            tag[0] <= '{valid: accept, last: gen_last};
            for (int k = 1; k < PIPELINE_DELAY; k++) tag[k] <= tag[k-1];
        end
    end

    assign fifo_wr = pipe_en & tag[PIPELINE_DELAY-1].valid;
    assign fifo_rd = m_axis_tvalid & m_axis_tready;

    lrf_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (s_axis_aclk),
        .rst_n   (s_axis_aresetn),
        .wr_en   (fifo_wr),
        .wr_data ({pipe_data, tag[PIPELINE_DELAY-1].last}),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign m_axis_tvalid = ~fifo_empty;
    // Head is masked while empty so the output bus reads zero after reset.
    assign m_axis_tdata  = m_axis_tvalid ? fifo_head[DATA_WIDTH:1] : '0;
    assign m_axis_tlast  = m_axis_tvalid & fifo_head[0];

    a_credit_holds : assert property (@(posedge s_axis_aclk) disable iff (!s_axis_aresetn)
        !(fifo_full && s_axis_tready));

endmodule

// File: tb/tb_lrf_axis_out_stage.sv
// Randomized bench for lrf_axis_out_stage: scoreboard of accepted beats against
// the output stream, plus cycle-level checks of ready, advance enable and framing.
module tb_lrf_axis_out_stage;

    localparam int PPB = 16;
    localparam int DIM = 64;
    localparam int PD  = 3;
    localparam int FD  = 8;
    localparam int DW  = 8 * PPB;
    localparam int BPI = DIM * DIM / PPB;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic          pipe_en;
    logic [DW-1:0] pipe_data;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          frame_err;
    logic [DW-1:0] s_data;

    int checks = 0;
    int errors = 0;

    lrf_axis_out_stage #(
        .PIXELS_PER_BEAT (PPB),
        .IMAGE_DIM       (DIM),
        .PIPELINE_DELAY  (PD),
        .FIFO_DEPTH      (FD),
        .DATA_WIDTH      (DW)
    ) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tlast   (s_tlast),
        .s_axis_tready  (s_tready),
        .pipe_en        (pipe_en),
        .pipe_data      (pipe_data),
        .m_axis_tdata   (m_tdata),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .m_axis_tlast   (m_tlast),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    // Stand-in for the fusion datapath: PD stages advancing on pipe_en, output inverted.
    logic [DW-1:0] dp [PD];
    always @(posedge clk) begin
        if (pipe_en) begin
            dp[0] <= s_data;
            for (int k = 1; k < PD; k++) dp[k] <= dp[k-1];
        end
    end
    assign pipe_data = ~dp[PD-1];

    task automatic chk(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Reference model: everything accepted and not yet emitted sits in sb.
    beat_t sb [$];
    beat_t e;
    int    acc_idx, out_total, tlast_seen, pe_cnt, cyc, last_acc, first_acc, first_out;
    bit    armed, have_acc, exp_ferr, acc;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            acc_idx    = 0;
            out_total  = 0;
            tlast_seen = 0;
            exp_ferr   = 1'b0;
            armed      = 1'b0;
            have_acc   = 1'b0;
            first_acc  = -1;
            first_out  = -1;
        end else begin
            acc = s_tvalid && s_tready;
            chk("s_tready", s_tready, armed && (sb.size() < FD));
            chk("pipe_en", pipe_en, acc || (have_acc && (cyc - last_acc) <= PD));
            chk("frame_err", frame_err, exp_ferr);
            if (m_tvalid && sb.size() == 0) chk("spurious_tvalid", m_tvalid, 1'b0);
            if (m_tvalid && sb.size() != 0) begin
                chk("tdata", m_tdata, sb[0].data);
                chk("tlast", m_tlast, sb[0].last);
                if (first_out < 0) first_out = cyc;
                if (m_tready) begin
                    if (m_tlast) tlast_seen++;
                    void'(sb.pop_front());
                    out_total++;
                end
            end
            if (pipe_en) pe_cnt++;
            if (acc) begin
                e.data = ~s_data;
                e.last = (acc_idx % BPI) == BPI - 1;
                if (s_tlast !== e.last) exp_ferr = 1'b1;
                sb.push_back(e);
                acc_idx++;
                last_acc = cyc;
                have_acc = 1'b1;
                if (first_acc < 0) first_acc = cyc;
            end
            armed = 1'b1;
        end
        cyc++;
    end

    // Driver: holds a beat until accepted, tlast from its own beat index.
    int sent     = 0;
    int err_beat = -1;

    task automatic cycle(input bit v, input bit r);
        bit a;
        @(negedge clk);
        a = s_tvalid && s_tready;
        @(posedge clk);
        #1;
        if (a) sent++;
        if (a || !s_tvalid) begin
            s_data  = rand_beat();
            s_tlast = ((sent % BPI) == BPI - 1) || (sent == err_beat);
        end
        s_tvalid = v;
        m_tready = r;
    endtask

    task automatic run_until_acc(input int target, input bit r);
        int n = 0;
        while (acc_idx < target && n < 3000) begin
            cycle(1'b1, r);
            n++;
        end
        chk("acc_budget", acc_idx >= target, 1'b1);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && (sb.size() != 0 || m_tvalid || pipe_en); i++) cycle(1'b0, 1'b1);
        chk("drain_sb_empty", sb.size(), 0);
        chk("drain_tvalid", m_tvalid, 1'b0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_m_tvalid"}, m_tvalid, 1'b0);
        chk({tag, "_m_tlast"}, m_tlast, 1'b0);
        chk({tag, "_m_tdata"}, m_tdata, '0);
        chk({tag, "_s_tready"}, s_tready, 1'b0);
        chk({tag, "_pipe_en"}, pipe_en, 1'b0);
        chk({tag, "_frame_err"}, frame_err, 1'b0);
    endtask

    logic [DW-1:0] held;
    int            o0, p0;

    initial begin
        rst_n    = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_data   = '0;
        m_tready = 1'b0;
        pe_cnt   = 0;
        cyc      = 0;
        #1 rst_n = 1'b0;
        #1 chk_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) cycle(1'b0, 1'b1);

        // Streaming at full rate, then a 20-cycle downstream stall mid-frame.
        run_until_acc(300, 1'b1);
        chk("latency", first_out - first_acc, PD + 1);
        cycle(1'b1, 1'b0);
        held = m_tdata;
        repeat (19) cycle(1'b1, 1'b0);
        chk("stall_head_stable", m_tdata, held);
        chk("stall_tready", s_tready, 1'b0);
        chk("stall_used", sb.size(), FD);
        cycle(1'b1, 1'b1);
        o0 = out_total;
        repeat (10) cycle(1'b1, 1'b1);
        chk("resume_rate", out_total - o0, 10);
        run_until_acc(2 * BPI, 1'b1);
        cycle(1'b0, 1'b1);
        wait_drain(100);
        chk("wrap_tlast_count", tlast_seen, 2);

        // Drain: five beats, then three bubble advances and idle.
        p0 = pe_cnt;
        o0 = out_total;
        repeat (5) cycle(1'b1, 1'b1);
        repeat (12) cycle(1'b0, 1'b1);
        chk("drain_pe_cycles", pe_cnt - p0, 8);
        chk("drain_out", out_total - o0, 5);
        chk("drain_pe_idle", pipe_en, 1'b0);

        // Reset with a full FIFO mid-frame.
        for (int i = 0; i < 40 && s_tready; i++) cycle(1'b1, 1'b0);
        chk("fill_tready_low", s_tready, 1'b0);
        repeat (3) cycle(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("midreset");
        s_tvalid = 1'b0;
        sent     = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) cycle(1'b0, 1'b1);

        // Framing error on beat 100 of the restarted frame.
        err_beat = 100;
        run_until_acc(50, 1'b1);
        chk("ferr_before", frame_err, 1'b0);
        run_until_acc(BPI + 1, 1'b1);
        chk("ferr_sticky", frame_err, 1'b1);
        cycle(1'b0, 1'b1);
        wait_drain(100);
        chk("ferr_tlast_count", tlast_seen, 1);
        err_beat = -1;

        // Random valid/ready traffic.
        repeat (600) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        cycle(1'b0, 1'b1);
        wait_drain(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
